// File: rtl/mtsp_lmem_resp.sv
// Local-memory request/response block: in-order request FIFO feeding a 128-bit
// byte-maskable array, with a two-stage registered load writeback path.
module mtsp_lmem_resp #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int GPR_W      = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               MEM_nEN,
    input  logic               MEM_WRITE,
    input  logic [31:0]        MEM_ADDR,
    input  logic [GPR_W-1:0]   MEM_SRC,
    input  logic [127:0]       MEM_DATA_0,
    input  logic [127:0]       MEM_DATA_1,
    output logic               MEM_BUSY,
    output logic               WB_nEN,
    output logic [GPR_W-1:0]   WB_DST,
    output logic [127:0]       WB_DATA,
    output logic               ERR_OVF
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic             write;
        logic [31:0]      addr;
        logic [GPR_W-1:0] src;
        logic [127:0]     data;
        logic [15:0]      be;
    } req_t;

    req_t         r_fifo [FIFO_DEPTH];
    logic [127:0] r_mem  [2**ADDR_W];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             r_s1_valid;
    logic [GPR_W-1:0] r_s1_dst;
    logic [127:0]     r_s1_data;

    logic             w_req;
    logic             w_pop;
    logic             w_full;
    logic             w_push;
    logic             w_drop;
    req_t             w_head;
    logic             w_in_range;
    logic [ADDR_W-1:0] w_idx;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_unused_ctl;

    assign w_req       = !MEM_nEN && !RST;
    assign w_pop       = (r_count != '0) && !RST;
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_push      = w_req && (!w_full || w_pop);
    assign w_drop      = w_req && w_full && !w_pop;
    assign w_head      = r_fifo[r_rd_ptr];
    assign w_in_range  = (w_head.addr[31:ADDR_W] == '0);
    assign w_idx       = w_head.addr[ADDR_W-1:0];
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_unused_ctl = ^MEM_DATA_1[127:16];

    // NOTE: storage arrays carry no reset; only the control state that gives them meaning is reset.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= '{write: MEM_WRITE, addr: MEM_ADDR, src: MEM_SRC,
                                  data: MEM_DATA_0, be: MEM_DATA_1[15:0]};
        end
    end

    always_ff @(posedge CLK) begin
        if (w_pop && w_head.write && w_in_range) begin
            for (int i = 0; i < 16; i++) begin
                if (w_head.be[i]) r_mem[w_idx][i*8 +: 8] <= w_head.data[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_pop && !w_head.write) begin
            r_s1_dst  <= w_head.src;
            r_s1_data <= w_in_range ? r_mem[w_idx] : '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_s1_valid <= 1'b0;
            WB_nEN     <= 1'b1;
            WB_DST     <= '0;
            WB_DATA    <= '0;
            MEM_BUSY   <= 1'b0;
            ERR_OVF    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count    <= w_count_nxt;
            r_s1_valid <= w_pop && !w_head.write;
            WB_nEN     <= !r_s1_valid;
            if (r_s1_valid) begin
                WB_DST  <= r_s1_dst;
                WB_DATA <= r_s1_data;
            end
            MEM_BUSY <= (w_count_nxt >= CNT_W'(FIFO_DEPTH - 1));
            if (w_drop) ERR_OVF <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mtsp_lmem_resp.sv
// Scoreboard bench for mtsp_lmem_resp: directed scenarios plus random traffic
// checked against an array-based memory model.
module tb_mtsp_lmem_resp;

    localparam int ADDR_W = 10;
    localparam int GPR_W  = 6;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             MEM_nEN = 1'b1;
    logic             MEM_WRITE = 1'b0;
    logic [31:0]      MEM_ADDR = '0;
    logic [GPR_W-1:0] MEM_SRC = '0;
    logic [127:0]     MEM_DATA_0 = '0;
    logic [127:0]     MEM_DATA_1 = '0;
    logic             MEM_BUSY;
    logic             WB_nEN;
    logic [GPR_W-1:0] WB_DST;
    logic [127:0]     WB_DATA;
    logic             ERR_OVF;

    mtsp_lmem_resp #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4), .GPR_W(GPR_W)) dut (
        .CLK(CLK), .RST(RST), .MEM_nEN(MEM_nEN), .MEM_WRITE(MEM_WRITE),
        .MEM_ADDR(MEM_ADDR), .MEM_SRC(MEM_SRC), .MEM_DATA_0(MEM_DATA_0),
        .MEM_DATA_1(MEM_DATA_1), .MEM_BUSY(MEM_BUSY), .WB_nEN(WB_nEN),
        .WB_DST(WB_DST), .WB_DATA(WB_DATA), .ERR_OVF(ERR_OVF)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [GPR_W-1:0] dst;
        logic [127:0]     data;
        int               due;   // expected writeback cycle, -1 when untimed
    } exp_t;

    exp_t         sb[$];
    logic [127:0] model_mem [2**ADDR_W];
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] model_read(input logic [31:0] addr);
        if (addr[31:ADDR_W] != '0) return '0;
        return model_mem[addr[ADDR_W-1:0]];
    endfunction

    // Drive one request for one cycle; loads push their expected writeback.
    task automatic issue(input bit wr, input logic [31:0] addr, input logic [GPR_W-1:0] src,
                         input logic [127:0] d0, input logic [15:0] be,
                         input bit expect_wb, input bit timed);
        @(posedge CLK); #1;
        MEM_nEN    = 1'b0;
        MEM_WRITE  = wr;
        MEM_ADDR   = addr;
        MEM_SRC    = src;
        MEM_DATA_0 = d0;
        MEM_DATA_1 = {{3{$urandom()}}, 16'($urandom()), be};
        if (wr) begin
            if (addr[31:ADDR_W] == '0) begin
                for (int i = 0; i < 16; i++)
                    if (be[i]) model_mem[addr[ADDR_W-1:0]][i*8 +: 8] = d0[i*8 +: 8];
            end
        end else if (expect_wb) begin
            sb.push_back('{dst: src, data: model_read(addr), due: timed ? cyc + 3 : -1});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
            MEM_nEN = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wb_nen"}, 128'(WB_nEN), 128'(1));
        check({tag, "_wb_dst"}, 128'(WB_DST), 128'(0));
        check({tag, "_wb_data"}, WB_DATA, 128'(0));
        check({tag, "_busy"}, 128'(MEM_BUSY), 128'(0));
        check({tag, "_ovf"}, 128'(ERR_OVF), 128'(0));
    endtask

    task automatic drain();
        int budget = 60;
        while (sb.size() != 0 && budget > 0) begin
            idle(1);
            budget--;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: %0d writebacks outstanding, required 0", sb.size());
            sb.delete();
        end
        idle(3);
    endtask

    // Writeback monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!WB_nEN && !RST) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL wb_unexpected: got WB dst=%0d data=%h, required none (cycle %0d)",
                             WB_DST, WB_DATA, cyc);
                end else begin
                    e = sb.pop_front();
                    check("wb_dst", 128'(WB_DST), 128'(e.dst));
                    check("wb_data", WB_DATA, e.data);
                    if (e.due >= 0) check("wb_cycle", 128'(cyc), 128'(e.due));
                end
            end
        end
    end

    initial begin
        logic [127:0] pat;
        logic [31:0]  ra;

        idle(3);
        RST = 1'b0;
        check_reset_outputs("rst_init");

        // Give the 16 test addresses known contents.
        for (int a = 0; a < 16; a++) issue(1'b1, 32'(a), '0, '0, 16'hFFFF, 1'b0, 1'b0);
        idle(3);

        // Store then load of the same entry, back to back.
        issue(1'b1, 32'd5, '0, {8{16'hA5A5}}, 16'hFFFF, 1'b0, 1'b0);
        issue(1'b0, 32'd5, 6'd3, '0, '0, 1'b1, 1'b1);
        drain();

        // Single-byte enable over a zero entry.
        issue(1'b1, 32'd7, '0, {120'($urandom()) << 8 | 120'hDEAD_BEEF_0000, 8'hFF}, 16'h0001, 1'b0, 1'b0);
        issue(1'b0, 32'd7, 6'd9, '0, '0, 1'b1, 1'b1);
        drain();
        check("byte_en_model", model_mem[7], 128'h0000_00FF);

        // Eight back-to-back loads: consecutive writebacks, no stall, no overflow.
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, 32'(i), 6'(10 + i), '0, '0, 1'b1, 1'b1);
            check("stream_busy", 128'(MEM_BUSY), 128'(0));
            check("stream_ovf", 128'(ERR_OVF), 128'(0));
        end
        drain();

        // Out-of-range load returns zero; out-of-range store leaves entry 0 alone.
        pat = {$urandom(), $urandom(), $urandom(), $urandom()};
        issue(1'b1, 32'd0, '0, pat, 16'hFFFF, 1'b0, 1'b0);
        issue(1'b0, 32'h0000_0400, 6'd21, '0, '0, 1'b1, 1'b1);
        issue(1'b1, 32'h0000_0400, '0, '1, 16'hFFFF, 1'b0, 1'b0);
        issue(1'b0, 32'd0, 6'd22, '0, '0, 1'b1, 1'b1);
        drain();

        // Reset while two loads are in flight: neither writes back.
        issue(1'b0, 32'd1, 6'd30, '0, '0, 1'b0, 1'b0);
        issue(1'b0, 32'd2, 6'd31, '0, '0, 1'b0, 1'b0);
        @(posedge CLK); #1;
        MEM_nEN = 1'b1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check_reset_outputs("rst_mid");
        idle(6);

        // Pops held off: three pushes raise BUSY, the fifth request is dropped.
        force dut.w_pop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, 32'(1 + i), 6'(40 + i), '0, '0, i < 4, 1'b0);
            if (i == 2) check("ovf_busy_after2", 128'(MEM_BUSY), 128'(0));
            if (i == 3) check("ovf_busy_after3", 128'(MEM_BUSY), 128'(1));
            check("ovf_before_drop", 128'(ERR_OVF), 128'(0));
        end
        idle(1);
        check("ovf_set", 128'(ERR_OVF), 128'(1));
        idle(2);
        release dut.w_pop;
        drain();
        check("ovf_sticky", 128'(ERR_OVF), 128'(1));
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check_reset_outputs("rst_ovf");

        // Random in-order traffic over the 16 known entries plus out-of-range hits.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                ra = 32'($urandom_range(0, 15));
                if ($urandom_range(0, 9) == 0) ra = ra | 32'h0000_0400;
                issue(1'($urandom()), ra, 6'($urandom()),
                      {$urandom(), $urandom(), $urandom(), $urandom()},
                      16'($urandom()), 1'b1, 1'b1);
            end
            check("rand_busy", 128'(MEM_BUSY), 128'(0));
        end
        drain();
        check("final_ovf", 128'(ERR_OVF), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mtsp_lmem_resp.md
MTSP_LMEM_RESP -- requirements
Module: mtsp_lmem_resp

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning the local memory holds 2^ADDR_W entries of 128 bits.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the request queue depth in entries (power of two, at least 2).
REQ-003 The block SHALL have parameter GPR_W, default 6, meaning the width of the destination GPR index.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, per the ports below.
REQ-005 The block SHALL have port CLK  in  1  the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port RST  in  1  synchronous reset, active high.
REQ-007 The block SHALL have port MEM_nEN  in  1  request strobe, active low, one request per cycle.
REQ-008 The block SHALL have port MEM_WRITE  in  1  1 = store, 0 = load.
REQ-009 The block SHALL have port MEM_ADDR  in  32  entry address (128-bit granularity).
REQ-010 The block SHALL have port MEM_SRC  in  GPR_W  load destination GPR index; ignored for stores.
REQ-011 The block SHALL have port MEM_DATA_0  in  128  store data.
REQ-012 The block SHALL have port MEM_DATA_1  in  128  store control; bits [15:0] are byte enables (bit i enables byte i), bits [127:16] are ignored.
REQ-013 The block SHALL have port MEM_BUSY  out  1  registered almost-full flag, asking the issuer to stall.
REQ-014 The block SHALL have port WB_nEN  out  1  load writeback strobe, active low.
REQ-015 The block SHALL have port WB_DST  out  GPR_W  writeback GPR index.
REQ-016 The block SHALL have port WB_DATA  out  128  writeback data.
REQ-017 The block SHALL have port ERR_OVF  out  1  sticky overflow flag: a request was dropped.

Function
REQ-018 The block SHALL push {WRITE, ADDR, SRC, DATA_0, MEM_DATA_1[15:0]} into the in-order request FIFO on every cycle with MEM_nEN=0 and RST=0, when the FIFO is not full or a pop occurs in the same cycle.
REQ-019 The block SHALL drop a request arriving while the FIFO is full with no pop in that cycle, and SHALL set ERR_OVF to 1 at that edge; ERR_OVF SHALL then hold 1 until reset.
REQ-020 The block SHALL pop the FIFO head in every cycle the FIFO is non-empty, giving a throughput of one request per cycle.
REQ-021 For a popped store, the block SHALL update only the enabled bytes of entry ADDR[ADDR_W-1:0] at the end of the pop cycle and SHALL produce no writeback.
REQ-022 For a popped load, the block SHALL register the array data together with SRC at the end of the pop cycle (stage S1), and SHALL register S1 into WB_nEN/WB_DST/WB_DATA at the following edge.
REQ-023 The block SHALL assert WB_nEN low for exactly one cycle per load; back-to-back loads SHALL produce consecutive writeback cycles.
REQ-024 With the FIFO empty, a load presented in cycle N SHALL produce WB_nEN=0 in cycle N+3; a store presented in cycle N SHALL be visible in the array from cycle N+2.
REQ-025 The block SHALL complete requests strictly in order; a load popped after a store to the same address SHALL return the stored data, with no forwarding path needed.
REQ-026 If MEM_ADDR[31:ADDR_W] is nonzero (out of range), a store SHALL be discarded and a load SHALL return WB_DATA=0 while still producing its writeback.
REQ-027 When WB_nEN=1, WB_DST and WB_DATA SHALL hold their last values.
REQ-028 MEM_BUSY SHALL be registered and SHALL be 1 in the cycle after the next-state occupancy reaches at least FIFO_DEPTH-1, and 0 otherwise.
REQ-029 The FIFO pointers SHALL be log2(FIFO_DEPTH) bits wide, wrap modulo FIFO_DEPTH, and use a separate occupancy counter of log2(FIFO_DEPTH)+1 bits.

Reset
REQ-030 While RST=1, the block SHALL empty the FIFO, discard S1, and drive WB_nEN=1, WB_DST=0, WB_DATA=0, MEM_BUSY=0 and ERR_OVF=0.
REQ-031 The block SHALL ignore any request presented in a cycle with RST=1, and SHALL not reset the memory array contents.
REQ-032 If reset is asserted mid-operation, any in-flight load SHALL produce no writeback.

Verification
REQ-033 The bench SHALL cover: store ADDR=5, DATA_0=0x...A5A5, byte enables 0xFFFF in cycle 0, then load ADDR=5, SRC=3 in cycle 1 -> WB_nEN=0 in cycle 4 with WB_DST=3 and WB_DATA=0x...A5A5.
REQ-034 The bench SHALL cover: store byte enables 0x0001, data 0xFF, over an entry holding 0 -> a following load returns 0x...00FF.
REQ-035 The bench SHALL cover: with FIFO_DEPTH=4, loads issued every cycle for 8 cycles -> 8 consecutive writebacks, MEM_BUSY=0 throughout (occupancy never exceeds 1), ERR_OVF=0.
REQ-036 The bench SHALL cover: a load to ADDR=0x0000_0400 with ADDR_W=10 -> WB_DATA=0 with the writeback still produced; a store to the same address leaves the array unchanged.
REQ-037 The bench SHALL cover: RST asserted for one cycle while two loads are in flight -> no writeback occurs, and all outputs equal their reset values in the next cycle.
REQ-038 The bench SHALL cover: with pops blocked by a test-only force, 5 requests issued -> the 5th is dropped, ERR_OVF=1 is held until RST, and MEM_BUSY=1 after the 3rd push.
